nmi_demux_tmo: RTL and testbench
================================

Name: nmi_demux_tmo

Overview:
- Parametrised NMI 1-to-N demultiplexer, the successor to the fixed-decode native IP wrapper.
- The address map is given as per-slave base/mask parameters, so it is no longer hard-coded with `NATV_IP_START`-style compares.
- Adds a registered slave select, a decode-error responder and a per-transaction timeout watchdog, plus sticky error status for sysctrl.
- Sits between the core NMI master port and the native IP slaves.

Parameters:
- NUM_SLV, 12, number of slave ports (1..32).
- SLV_BASE, {NUM_SLV{32'h0}}, packed NUM_SLV*32 bits; slave i base address at [i*32+:32].
- SLV_MASK, {NUM_SLV{32'hF000_0000}}, packed NUM_SLV*32 bits; slave i hits when (addr & mask) == (base & mask).
- TMO_CYCLES, 1024, cycles in BUSY before timeout; 0 disables the watchdog.
- ERR_RDATA, 32'hDEAD_BEEF, rdata returned on a decode or timeout error.

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  reset.
- m_valid_i  in  1  master request valid.
- m_addr_i  in  32  master address.
- m_wdata_i  in  32  master write data.
- m_wstrb_i  in  4  byte strobes; 0 means read.
- m_ready_o  out  1  master response strobe.
- m_rdata_o  out  32  master read data.
- s_valid_o  out  NUM_SLV  per-slave valid, one-hot or zero.
- s_addr_o  out  32  shared slave address.
- s_wdata_o  out  32  shared slave write data.
- s_wstrb_o  out  4  shared slave write strobes.
- s_ready_i  in  NUM_SLV  per-slave ready.
- s_rdata_i  in  NUM_SLV*32  per-slave read data, slave i at [i*32+:32].
- busy_o  out  1  transaction in flight.
- err_o  out  1  sticky error flag.
- err_type_o  out  1  error type: 0 = decode, 1 = timeout.
- err_addr_o  out  32  address of the first error since the last clear.
- err_clr_i  in  1  single-cycle clear of err_o, err_type_o and err_addr_o.

Behaviour:
- Clock and reset: single clock clk_i; reset rst_n_i is asynchronous, active-low.
- Reset values: all outputs 0, FSM in IDLE, counter 0.
- The master must hold valid, addr, wdata and wstrb stable until m_ready_o. s_addr/s_wdata/s_wstrb are passthrough of the master signals.
- Decode (combinational): hit[i] = ((m_addr_i ^ base_i) & mask_i) == 0. On multiple hits the lowest index wins.
- IDLE: when m_valid_i is high, latch sel = winning index.
  - Any hit: go to BUSY.
  - No hit: latch err_addr, go to DERR.
  - m_ready_o = 0 in IDLE.
- BUSY:
  - s_valid_o[sel] = m_valid_i; all other bits are 0.
  - m_ready_o = s_ready_i[sel] and m_rdata_o = s_rdata_i[sel], both combinational passthrough.
  - On s_ready_i[sel], return to IDLE.
  - Added latency is exactly 1 cycle, the select register.
  - Ready from an unselected slave is ignored.
- DERR: m_ready_o = 1 and m_rdata_o = ERR_RDATA for one cycle, then IDLE. Error latency is 2 cycles after valid is first seen. Writes are discarded.
- Timeout:
  - The counter clears on entry to BUSY and increments every BUSY cycle without ready.
  - When the counter reaches TMO_CYCLES-1 with no ready, s_valid_o is forced to 0 and the FSM goes to TERR.
  - TERR behaves like DERR but with err_type = 1.
  - Ready arriving in the same cycle as the terminal count wins: normal completion, no error.
  - A late slave ready after timeout is ignored.
- Master abort: if m_valid_i falls in BUSY without ready (protocol violation), go to IDLE with no response and no error.
- Error status:
  - On entry to DERR or TERR: err_o is set.
  - err_type_o and err_addr_o are captured only if err_o was 0, so the first error is kept.
  - err_clr_i clears all three. If a new error arrives in the same cycle, the new error wins and its type/address are captured.
- busy_o = 1 whenever the FSM is not in IDLE.
- Mid-transaction reset: all outputs return to 0 immediately; no response is issued.
- Widths: sel is $clog2(NUM_SLV) bits, minimum 1. The counter is $clog2(TMO_CYCLES+1) bits, minimum 1.

Decomposition:
- Package nmi_demux_pkg:
  - state enum {IDLE, BUSY, DERR, TERR}.
  - err_type enum {ERR_DECODE, ERR_TIMEOUT}.
  - NMI_AW = 32, NMI_DW = 32.
- Sub-module nmi_addr_dec: purely combinational hit vector plus lowest-index priority encoder, outputs {hit_any, sel_idx}. Reusable by future multi-master arbiters.

Test Plan:
- Config NUM_SLV=4, bases 0x1000_0000 / 0x4000_0000 / 0x5000_0000 / 0x1000_0000, mask 0xF000_0000. Read 0x4000_0010, slave1 ready 3 cycles later with 0x1234_5678 -> s_valid_o=4'b0010 one cycle after valid; m_ready_o with rdata 0x1234_5678; FSM back in IDLE.
- Overlap: access to 0x1000_0004 -> only s_valid_o[0] asserted (lowest index wins); slave3 never sees valid.
- Decode error: write 0x9000_0000 -> no s_valid_o; m_ready_o two cycles after valid with rdata 0xDEAD_BEEF; err_o=1, err_type_o=0, err_addr_o=0x9000_0000.
- Timeout, TMO_CYCLES=8: slave2 never ready -> s_valid_o[2] high for 8 cycles then drops; m_ready_o with 0xDEAD_BEEF; err_type_o stays 0 because the decode error is still sticky. Pulse err_clr_i and repeat -> err_type_o=1, err_addr_o equals the new address.
- Boundary: slave ready on exactly the terminal-count cycle -> normal completion, err_o remains 0. err_clr_i coincident with a new decode error -> err_o stays 1 with the new address.
- Reset asserted while BUSY -> m_ready_o, s_valid_o and busy_o go to 0 asynchronously; after release the next read completes normally.

Source files
------------

// File: rtl/nmi_demux_pkg.sv
// Shared types and constants for the NMI 1-to-N demultiplexer and its address decoder.
package nmi_demux_pkg;

   localparam int unsigned NMI_AW = 32;
   localparam int unsigned NMI_DW = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DERR = 2'd2,
      TERR = 2'd3
   } state_t;

   typedef enum logic {
      ERR_DECODE  = 1'b0,
      ERR_TIMEOUT = 1'b1
   } err_type_t;

   // Index/counter widths never collapse to zero bits, even for degenerate sizes.
   function automatic int unsigned min1_clog2(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/nmi_addr_dec.sv
// Combinational base/mask address decoder with lowest-index priority among overlapping windows.
module nmi_addr_dec
   import nmi_demux_pkg::*;
#(
   parameter int unsigned                  NUM_SLV  = 12,
   parameter logic [NUM_SLV*NMI_AW-1:0]    SLV_BASE = {NUM_SLV{32'h0}},
   parameter logic [NUM_SLV*NMI_AW-1:0]    SLV_MASK = {NUM_SLV{32'hF000_0000}},
   parameter int unsigned                  SEL_W    = min1_clog2(NUM_SLV)
) (
   input  logic [NMI_AW-1:0] addr_i,
   output logic [NUM_SLV-1:0] hit_o,
   output logic              hit_any_o,
   output logic [SEL_W-1:0]  sel_idx_o
);

   always_comb begin
      hit_o = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         hit_o[i] = ((addr_i ^ SLV_BASE[i*NMI_AW +: NMI_AW]) & SLV_MASK[i*NMI_AW +: NMI_AW]) == '0;
      end
   end

   // Scanning downward lets the lowest hitting index overwrite any higher one.
   always_comb begin
      hit_any_o = 1'b0;
      sel_idx_o = '0;
      for (int i = NUM_SLV - 1; i >= 0; i--) begin
         if (hit_o[i]) begin
            hit_any_o = 1'b1;
            sel_idx_o = SEL_W'(i);
         end
      end
   end

endmodule

// File: rtl/nmi_demux_tmo.sv
// NMI 1-to-N demultiplexer: registered slave select, decode-error responder,
// per-transaction timeout watchdog and sticky first-error status.
module nmi_demux_tmo
   import nmi_demux_pkg::*;
#(
   parameter int unsigned                  NUM_SLV    = 12,
   parameter logic [NUM_SLV*NMI_AW-1:0]    SLV_BASE   = {NUM_SLV{32'h0}},
   parameter logic [NUM_SLV*NMI_AW-1:0]    SLV_MASK   = {NUM_SLV{32'hF000_0000}},
   parameter int unsigned                  TMO_CYCLES = 1024,
   parameter logic [NMI_DW-1:0]            ERR_RDATA  = 32'hDEAD_BEEF
) (
   input  logic                      clk_i,
   input  logic                      rst_n_i,
   input  logic                      m_valid_i,
   input  logic [NMI_AW-1:0]         m_addr_i,
   input  logic [NMI_DW-1:0]         m_wdata_i,
   input  logic [3:0]                m_wstrb_i,
   output logic                      m_ready_o,
   output logic [NMI_DW-1:0]         m_rdata_o,
   output logic [NUM_SLV-1:0]        s_valid_o,
   output logic [NMI_AW-1:0]         s_addr_o,
   output logic [NMI_DW-1:0]         s_wdata_o,
   output logic [3:0]                s_wstrb_o,
   input  logic [NUM_SLV-1:0]        s_ready_i,
   input  logic [NUM_SLV*NMI_DW-1:0] s_rdata_i,
   output logic                      busy_o,
   output logic                      err_o,
   output logic                      err_type_o,
   output logic [NMI_AW-1:0]         err_addr_o,
   input  logic                      err_clr_i
);

   localparam int unsigned      SEL_W    = min1_clog2(NUM_SLV);
   localparam int unsigned      CNT_W    = min1_clog2(TMO_CYCLES + 1);
   localparam bit               TMO_EN   = (TMO_CYCLES != 0);
   localparam logic [CNT_W-1:0] TMO_LAST = TMO_EN ? CNT_W'(TMO_CYCLES - 1) : '0;

   state_t              state_q, state_d;
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                err_q, err_d;
   err_type_t           err_type_q, err_type_d;
   logic [NMI_AW-1:0]   err_addr_q, err_addr_d;

   logic [NUM_SLV-1:0]  dec_hit;
   logic                dec_hit_any;
   logic [SEL_W-1:0]    dec_sel;
   logic                sel_ready;
   logic [NMI_DW-1:0]   sel_rdata;
   logic                err_set;
   err_type_t           err_set_type;

   nmi_addr_dec #(
      .NUM_SLV  (NUM_SLV),
      .SLV_BASE (SLV_BASE),
      .SLV_MASK (SLV_MASK),
      .SEL_W    (SEL_W)
   ) u_dec (
      .addr_i    (m_addr_i),
      .hit_o     (dec_hit),
      .hit_any_o (dec_hit_any),
      .sel_idx_o (dec_sel)
   );

   assign s_addr_o  = m_addr_i;
   assign s_wdata_o = m_wdata_i;
   assign s_wstrb_o = m_wstrb_i;
   assign busy_o    = (state_q != IDLE);

   always_comb begin
      sel_ready = 1'b0;
      sel_rdata = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         if (sel_q == SEL_W'(i)) begin
            sel_ready = s_ready_i[i];
            sel_rdata = s_rdata_i[i*NMI_DW +: NMI_DW];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      cnt_d        = cnt_q;
      err_set      = 1'b0;
      err_set_type = ERR_DECODE;
      m_ready_o    = 1'b0;
      m_rdata_o    = '0;
      s_valid_o    = '0;
      case (state_q)
         IDLE: begin
            if (m_valid_i) begin
               sel_d = dec_sel;
               if (dec_hit_any) begin
                  state_d = BUSY;
                  cnt_d   = '0;
               end else begin
                  state_d = DERR;
                  err_set = 1'b1;
               end
            end
         end
         BUSY: begin
            for (int i = 0; i < NUM_SLV; i++) begin
               s_valid_o[i] = m_valid_i && (sel_q == SEL_W'(i));
            end
            m_ready_o = sel_ready;
            m_rdata_o = sel_rdata;
            // Ready beats the terminal count; a dropped valid is an abort with no response.
            if (sel_ready || !m_valid_i) begin
               state_d = IDLE;
            end else if (TMO_EN && (cnt_q == TMO_LAST)) begin
               state_d      = TERR;
               err_set      = 1'b1;
               err_set_type = ERR_TIMEOUT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DERR, TERR: begin
            m_ready_o = 1'b1;
            m_rdata_o = ERR_RDATA;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // A same-cycle clear lets a new error overwrite the captured type/address.
   always_comb begin
      err_d      = err_q;
      err_type_d = err_type_q;
      err_addr_d = err_addr_q;
      if (err_clr_i) begin
         err_d      = 1'b0;
         err_type_d = ERR_DECODE;
         err_addr_d = '0;
      end
      if (err_set) begin
         err_d = 1'b1;
         if (!err_q || err_clr_i) begin
            err_type_d = err_set_type;
            err_addr_d = m_addr_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= IDLE;
         sel_q      <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
         err_type_q <= ERR_DECODE;
         err_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
         err_type_q <= err_type_d;
         err_addr_q <= err_addr_d;
      end
   end

   assign err_o      = err_q;
   assign err_type_o = err_type_q;
   assign err_addr_o = err_addr_q;

endmodule

// File: tb/tb_nmi_demux_tmo.sv
// Directed bench for nmi_demux_tmo: four slaves with an overlapping window, watchdog of 8 cycles.
module tb_nmi_demux_tmo;

   logic         clk_i = 1'b0;
   logic         rst_n_i;
   logic         m_valid_i;
   logic [31:0]  m_addr_i;
   logic [31:0]  m_wdata_i;
   logic [3:0]   m_wstrb_i;
   logic         m_ready_o;
   logic [31:0]  m_rdata_o;
   logic [3:0]   s_valid_o;
   logic [31:0]  s_addr_o;
   logic [31:0]  s_wdata_o;
   logic [3:0]   s_wstrb_o;
   logic [3:0]   s_ready_i;
   logic [127:0] s_rdata_i;
   logic         busy_o;
   logic         err_o;
   logic         err_type_o;
   logic [31:0]  err_addr_o;
   logic         err_clr_i;

   int n_tests = 0;
   int n_fail  = 0;

   nmi_demux_tmo #(
      .NUM_SLV    (4),
      .SLV_BASE   ({32'h1000_0000, 32'h5000_0000, 32'h4000_0000, 32'h1000_0000}),
      .SLV_MASK   ({4{32'hF000_0000}}),
      .TMO_CYCLES (8),
      .ERR_RDATA  (32'hDEAD_BEEF)
   ) dut (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .m_valid_i  (m_valid_i),
      .m_addr_i   (m_addr_i),
      .m_wdata_i  (m_wdata_i),
      .m_wstrb_i  (m_wstrb_i),
      .m_ready_o  (m_ready_o),
      .m_rdata_o  (m_rdata_o),
      .s_valid_o  (s_valid_o),
      .s_addr_o   (s_addr_o),
      .s_wdata_o  (s_wdata_o),
      .s_wstrb_o  (s_wstrb_o),
      .s_ready_i  (s_ready_i),
      .s_rdata_i  (s_rdata_i),
      .busy_o     (busy_o),
      .err_o      (err_o),
      .err_type_o (err_type_o),
      .err_addr_o (err_addr_o),
      .err_clr_i  (err_clr_i)
   );

   always #5 clk_i = ~clk_i;

   // dly: cycle (counted from the edge that first samples valid) at which slave slv raises ready; 0 = never.
   typedef struct {
      logic [31:0] addr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
      logic        clr;
      int          dly;
      int          slv;
      logic [3:0]  ign;
      logic [3:0]  exp_sv;
      int          exp_vc;
      int          exp_lat;
      logic [31:0] exp_rd;
      logic        exp_err;
      logic        exp_et;
      logic [31:0] exp_ea;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_txn(input int idx, input vec_t v);
      logic [3:0]  first_sv;
      logic [3:0]  seen;
      int          vcyc;
      int          lat;
      logic [31:0] rd;
      bit          done;
      if (v.clr) begin
         err_clr_i = 1'b1;
         @(posedge clk_i); #1;
         err_clr_i = 1'b0;
      end
      m_valid_i = 1'b1;
      m_addr_i  = v.addr;
      m_wdata_i = v.wdata;
      m_wstrb_i = v.wstrb;
      s_ready_i = v.ign;
      first_sv = '0; seen = '0; vcyc = 0; lat = -1; rd = '0; done = 1'b0;
      for (int c = 1; c <= 40 && !done; c++) begin
         @(posedge clk_i); #1;
         if (v.dly != 0 && c >= v.dly) s_ready_i = v.ign | (4'b0001 << v.slv);
         #1;
         if (c == 1) first_sv = s_valid_o;
         seen |= s_valid_o;
         if (s_valid_o != '0) vcyc++;
         if (m_ready_o) begin
            lat  = c;
            rd   = m_rdata_o;
            done = 1'b1;
         end
      end
      @(posedge clk_i); #1;
      m_valid_i = 1'b0;
      s_ready_i = '0;
      chk($sformatf("v%0d busy_after_resp", idx), 32'(busy_o), 32'd0);
      @(posedge clk_i); #1;
      chk($sformatf("v%0d s_valid_first", idx), 32'(first_sv), 32'(v.exp_sv));
      chk($sformatf("v%0d s_valid_seen", idx), 32'(seen), 32'(v.exp_sv));
      chk($sformatf("v%0d valid_cycles", idx), 32'(vcyc), 32'(v.exp_vc));
      chk($sformatf("v%0d ready_latency", idx), 32'(lat), 32'(v.exp_lat));
      chk($sformatf("v%0d rdata", idx), rd, v.exp_rd);
      chk($sformatf("v%0d err_o", idx), 32'(err_o), 32'(v.exp_err));
      chk($sformatf("v%0d err_type", idx), 32'(err_type_o), 32'(v.exp_et));
      chk($sformatf("v%0d err_addr", idx), err_addr_o, v.exp_ea);
   endtask

   initial begin
      //           addr          wstrb  wdata         clr  dly slv ign      exp_sv   vc lat exp_rd        err  et   exp_ea
      vecs[0] = '{32'h4000_0010, 4'h0, 32'h0,        1'b0, 3,  1, 4'b0000, 4'b0010, 3, 3, 32'h1234_5678, 1'b0, 1'b0, 32'h0};
      vecs[1] = '{32'h1000_0004, 4'hF, 32'hCAFE_F00D, 1'b0, 2,  0, 4'b0000, 4'b0001, 2, 2, 32'hAAAA_0000, 1'b0, 1'b0, 32'h0};
      vecs[2] = '{32'h5000_0000, 4'h0, 32'h0,        1'b0, 1,  2, 4'b1011, 4'b0100, 1, 1, 32'h2222_2222, 1'b0, 1'b0, 32'h0};
      vecs[3] = '{32'h4FFF_FFFC, 4'h0, 32'h0,        1'b0, 8,  1, 4'b0000, 4'b0010, 8, 8, 32'h1234_5678, 1'b0, 1'b0, 32'h0};
      vecs[4] = '{32'h9000_0000, 4'h3, 32'h1111_0000, 1'b0, 0,  0, 4'b0000, 4'b0000, 0, 1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h9000_0000};
      vecs[5] = '{32'h5000_0100, 4'h0, 32'h0,        1'b0, 0,  2, 4'b0000, 4'b0100, 8, 9, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h9000_0000};
      vecs[6] = '{32'h5000_0200, 4'h0, 32'h0,        1'b1, 0,  2, 4'b0000, 4'b0100, 8, 9, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h5000_0200};
      vecs[7] = '{32'h1000_0008, 4'h0, 32'h0,        1'b1, 1,  0, 4'b0000, 4'b0001, 1, 1, 32'hAAAA_0000, 1'b0, 1'b0, 32'h0};

      rst_n_i   = 1'b0;
      m_valid_i = 1'b0;
      m_addr_i  = '0;
      m_wdata_i = '0;
      m_wstrb_i = '0;
      s_ready_i = '0;
      err_clr_i = 1'b0;
      s_rdata_i = {32'h3333_3333, 32'h2222_2222, 32'h1234_5678, 32'hAAAA_0000};
      repeat (3) @(posedge clk_i);
      #1;
      chk("reset m_ready", 32'(m_ready_o), 32'd0);
      chk("reset m_rdata", m_rdata_o, 32'd0);
      chk("reset s_valid", 32'(s_valid_o), 32'd0);
      chk("reset busy", 32'(busy_o), 32'd0);
      chk("reset err", 32'(err_o), 32'd0);
      chk("reset err_type", 32'(err_type_o), 32'd0);
      chk("reset err_addr", err_addr_o, 32'd0);
      rst_n_i = 1'b1;
      @(posedge clk_i); #1;

      for (int i = 0; i < 8; i++) run_txn(i, vecs[i]);

      // Clear coincident with a new decode error: the new error is kept.
      m_valid_i = 1'b1; m_addr_i = 32'hA000_0000; m_wstrb_i = 4'h0;
      @(posedge clk_i); #1;
      chk("derr_a ready", 32'(m_ready_o), 32'd1);
      @(posedge clk_i); #1;
      m_valid_i = 1'b0;
      @(posedge clk_i); #1;
      chk("derr_a err_addr", err_addr_o, 32'hA000_0000);
      m_valid_i = 1'b1; m_addr_i = 32'hB000_0000; err_clr_i = 1'b1;
      @(posedge clk_i); #1;
      err_clr_i = 1'b0;
      chk("clr_coinc ready", 32'(m_ready_o), 32'd1);
      chk("clr_coinc rdata", m_rdata_o, 32'hDEAD_BEEF);
      chk("clr_coinc err", 32'(err_o), 32'd1);
      chk("clr_coinc err_addr", err_addr_o, 32'hB000_0000);
      chk("clr_coinc err_type", 32'(err_type_o), 32'd0);
      @(posedge clk_i); #1;
      m_valid_i = 1'b0;
      @(posedge clk_i); #1;

      // Master abort: valid drops in BUSY without ready.
      m_valid_i = 1'b1; m_addr_i = 32'h4000_0000;
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      m_valid_i = 1'b0;
      #1;
      chk("abort s_valid", 32'(s_valid_o), 32'd0);
      chk("abort m_ready", 32'(m_ready_o), 32'd0);
      @(posedge clk_i); #1;
      chk("abort busy", 32'(busy_o), 32'd0);
      chk("abort err_addr", err_addr_o, 32'hB000_0000);

      // Asynchronous reset while BUSY, with a ready arriving at the same moment.
      m_valid_i = 1'b1; m_addr_i = 32'h4000_0000;
      @(posedge clk_i); #1;
      chk("pre_rst s_valid", 32'(s_valid_o), 32'b0010);
      #2;
      rst_n_i   = 1'b0;
      s_ready_i = 4'b0010;
      #1;
      chk("rst_busy m_ready", 32'(m_ready_o), 32'd0);
      chk("rst_busy s_valid", 32'(s_valid_o), 32'd0);
      chk("rst_busy busy", 32'(busy_o), 32'd0);
      chk("rst_busy err", 32'(err_o), 32'd0);
      m_valid_i = 1'b0;
      s_ready_i = '0;
      repeat (2) @(posedge clk_i);
      #1;
      rst_n_i = 1'b1;
      @(posedge clk_i); #1;
      run_txn(8, vecs[0]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
